// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, ROM data and issue outputs.
// master = sequencer side, slave = ROM / execute / control side.
interface fetch_sequencer_if #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 12
);
  logic               run;
  logic               step;
  logic [INSTR_W-1:0] instr_in;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               halted;

  modport master (
    input  run,
    input  step,
    input  instr_in,
    input  branch_taken,
    input  branch_target,
    output pc,
    output instr_out,
    output instr_valid,
    output halted
  );

  modport slave (
    output run,
    output step,
    output instr_in,
    output branch_taken,
    output branch_target,
    input  pc,
    input  instr_out,
    input  instr_valid,
    input  halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC / fetch control ahead of the instruction ROM, single-step or free-run.
// Optional FETCH_PC_WRAP_EN: pc wraps to 0 after the last ROM word.
module fetch_sequencer #(
  parameter int         PC_W    = 3,
  parameter int         INSTR_W = 12,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input logic            clk,
  input logic            reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t             r_state;
  logic               r_step_q;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_halted;

  logic            w_step_rise;
  logic [PC_W-1:0] w_pc_next;
  logic            w_is_halt;
  logic            w_stop;

  assign w_step_rise = bus.step & ~r_step_q;
  assign w_pc_next   = bus.branch_taken ? bus.branch_target
                                        : r_pc + PC_W'(1);
  assign w_is_halt   = (r_instr[INSTR_W-1 -: 3] == HALT_OP);

`ifdef FETCH_PC_WRAP_EN
  assign w_stop = w_is_halt;
`else
  // Falling off the end of the ROM halts unless a branch redirects.
  logic w_pc_end;
  assign w_pc_end = (r_pc == '1) & ~bus.branch_taken;
  assign w_stop   = w_is_halt | w_pc_end;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_step_q <= 1'b0;
      r_pc     <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_step_q <= bus.step;
      r_valid  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.run || w_step_rise)
            r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_instr <= bus.instr_in;
          r_valid <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_stop) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= bus.run ? S_FETCH : S_IDLE;
          end
        end
        S_HALTED: begin
          r_halted <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.instr_out   = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: issue-order model plus literals.
// Builds with or without FETCH_PC_WRAP_EN.
module tb_fetch_sequencer;
  localparam int PC_W    = 3;
  localparam int INSTR_W = 12;

  logic clk = 1'b0;
  logic reset;

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_sequencer #(
    .PC_W(PC_W),
    .INSTR_W(INSTR_W),
    .HALT_OP(3'b111)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] rom [8];
  logic               br_en;
  logic [2:0]         br_pc;
  logic [2:0]         br_tgt;

  assign bus.instr_in      = rom[bus.pc];
  assign bus.branch_taken  = br_en && (bus.pc == br_pc);
  assign bus.branch_target = br_tgt;

  int errors = 0;
  int checks = 0;
  int q_pc[$];
  int obs[$];
  int n_valid;
  int last_v;
  int cyc = 0;
  bit cad_en;
  bit model_halts;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected issue order: walk the ROM applying halt, branch and end rules.
  task automatic model_build(input int maxn);
    int p;
    logic [INSTR_W-1:0] w;
    q_pc.delete();
    model_halts = 0;
    p = 0;
    for (int n = 0; n < maxn; n++) begin
      q_pc.push_back(p);
      w = rom[p];
      if (w[11:9] == 3'b111) begin
        model_halts = 1;
        break;
      end
      if (br_en && p == int'(br_pc)) p = int'(br_tgt);
      else if (p == 7) begin
`ifdef FETCH_PC_WRAP_EN
        p = 0;
`else
        model_halts = 1;
        break;
`endif
      end else p = p + 1;
    end
  endtask

  always @(negedge clk) begin : compare
    int p;
    cyc++;
    if (!reset && bus.instr_valid) begin
      n_valid++;
      obs.push_back(int'(bus.pc));
      if (q_pc.size() == 0) begin
        chk("unexpected_valid", bus.instr_valid, 0);
      end else begin
        p = q_pc.pop_front();
        chk("issue_pc", bus.pc, p);
        chk("issue_instr", bus.instr_out, rom[p[2:0]]);
      end
      chk("valid_while_halted", bus.halted, 0);
      if (cad_en && last_v >= 0)
        chk("run_cadence", cyc - last_v, 2);
      last_v = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_test();
    q_pc.delete();
    obs.delete();
    n_valid = 0;
    last_v  = -1;
  endtask

  task automatic do_reset();
    bus.run  = 1'b0;
    bus.step = 1'b0;
    br_en    = 1'b0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    start_test();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, bus.pc, 0);
    chk({tag, "_instr"}, bus.instr_out, 0);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_halted"}, bus.halted, 0);
  endtask

  task automatic wait_halt(input int budget);
    int k = 0;
    while (!bus.halted && k < budget) begin
      tick();
      k++;
    end
    chk("halt_timeout", bus.halted, 1);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (q_pc.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_timeout", q_pc.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = 12'(i * 12'h011);
    br_pc  = 3'd2;
    br_tgt = 3'd5;
    cad_en = 1'b0;
    start_test();

    // Reset values
    do_reset();
    check_reset_vals("rst");

    // Single step, with a step edge during ISSUE that must be ignored
    cad_en = 1'b0;
    start_test();
    q_pc.push_back(0);
    bus.step = 1'b1;
    tick();
    chk("step_n1_valid", bus.instr_valid, 0);
    chk("step_n1_pc", bus.pc, 0);
    bus.step = 1'b0;
    tick();
    chk("step_n2_valid", bus.instr_valid, 1);
    chk("step_n2_instr", bus.instr_out, 12'h000);
    chk("step_n2_pc", bus.pc, 0);
    bus.step = 1'b1;
    tick();
    chk("step_n3_valid", bus.instr_valid, 0);
    chk("step_n3_pc", bus.pc, 1);
    repeat (10) tick();
    chk("step_held_pulses", n_valid, 1);
    chk("step_held_pc", bus.pc, 1);

    q_pc.push_back(1);
    bus.step = 1'b0;
    tick();
    bus.step = 1'b1;
    tick();
    tick();
    chk("step2_valid", bus.instr_valid, 1);
    chk("step2_instr", bus.instr_out, 12'h011);
    tick();
    chk("step2_pc", bus.pc, 2);
    chk("step2_pulses", n_valid, 2);

    // Free run, no branches
    do_reset();
    cad_en = 1'b1;
    model_build(20);
    bus.run = 1'b1;
`ifdef FETCH_PC_WRAP_EN
    wait_drain(100);
    chk("run_no_halt", bus.halted, 0);
    chk("run_wrap_obs8", obs[8], 0);
    chk("run_wrap_obs9", obs[9], 1);
`else
    wait_halt(100);
    chk("run_end_pc", bus.pc, 7);
    chk("run_end_left", q_pc.size(), 0);
    chk("run_end_count", n_valid, 8);
    chk("run_obs7", obs[7], 7);
`endif

    // Taken branch at pc 2 to 5
    do_reset();
    br_en = 1'b1;
    model_build(12);
    bus.run = 1'b1;
`ifdef FETCH_PC_WRAP_EN
    wait_drain(100);
    chk("br_obs6", obs[6], 0);
`else
    wait_halt(100);
    chk("br_end_pc", bus.pc, 7);
    chk("br_count", n_valid, 6);
`endif
    chk("br_obs2", obs[2], 2);
    chk("br_obs3", obs[3], 5);

    // Halt opcode at pc 3, then poke step/run for 20 cycles
    do_reset();
    rom[3] = 12'hE00;
    model_build(20);
    bus.run = 1'b1;
    wait_halt(100);
    chk("halt_model", model_halts, 1);
    for (int i = 0; i < 20; i++) begin
      bus.step = i[0];
      bus.run  = i[1];
      tick();
    end
    chk("halt_pc", bus.pc, 3);
    chk("halt_flag", bus.halted, 1);
    chk("halt_instr", bus.instr_out, 12'hE00);
    chk("halt_count", n_valid, 4);
    do_reset();
    check_reset_vals("rst_from_halt");
    rom[3] = 12'h033;

    // Reset held 2 cycles mid-run, asserted while in FETCH
    model_build(20);
    cad_en  = 1'b1;
    bus.run = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_pc", bus.pc, 1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_mid1");
    tick();
    check_reset_vals("rst_mid2");
    reset = 1'b0;
    bus.run = 1'b0;
    start_test();
    repeat (4) tick();
    chk("post_rst_idle_pc", bus.pc, 0);
    chk("post_rst_pulses", n_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch control stage sitting directly upstream of the 8-entry × 12-bit instruction ROM. Generates the 3-bit `pc` address, captures the returned instruction into an instruction register, and issues it to the decode/execute stage one instruction at a time. Supports button single-step or free-run execution, taken branches, and a halt opcode.

## Interface
- `PC_W`, 3: program counter width; ROM depth is 2^`PC_W`.
- `INSTR_W`, 12: instruction width.
- `HALT_OP`, 3'b111: opcode in `instr_in[11:9]` that stops the sequencer.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `run`  in  1  level; 1 = free-run, 0 = single-step mode.
- `step`  in  1  level from debounced button; one rising edge = one instruction.
- `instr_in`  in  `INSTR_W`  combinational ROM output for the current `pc`.
- `branch_taken`  in  1  from execute stage, sampled only in ISSUE.
- `branch_target`  in  `PC_W`  next PC when `branch_taken`=1.
- `pc`  out  `PC_W`  ROM address (registered).
- `instr_out`  out  `INSTR_W`  instruction register.
- `instr_valid`  out  1  one-cycle pulse; `instr_out` is valid for execution.
- `halted`  out  1  1 while in HALTED.

## Operation
- Reset values: `pc`=0, `instr_out`=0, `instr_valid`=0, `halted`=0, state=IDLE, `step_q`=0.
- `step_q` registers `step` every cycle; `step_rise` = `step` & ~`step_q`.
- States:
  - IDLE: `pc` stable. If `run`=1 -> FETCH; else if `step_rise` -> FETCH; else stay.
  - FETCH: load `instr_out` <= `instr_in` (ROM at current `pc`); -> ISSUE.
  - ISSUE: `instr_valid`=1. Next PC = `branch_target` if `branch_taken`, else `pc`+1. If `instr_out[11:9]`==`HALT_OP` -> HALTED, `pc` held, branch ignored. Else update `pc`; -> FETCH if `run`=1, else IDLE.
  - HALTED: `halted`=1, `pc` and `instr_out` held; exit only through `reset`.
- `run` and `step_rise` both high in IDLE: `run` wins; behaviour is identical (-> FETCH).
- `step_rise` outside IDLE is ignored, not queued.
- `run` deasserted mid-instruction: current instruction completes ISSUE, then IDLE.
- PC arithmetic is `PC_W`-bit; overflow behaviour per Configuration.
- `instr_valid` is 0 in every state except ISSUE.

## Timing
- Step mode: `step` rises before edge N -> FETCH during cycle N+1 -> `instr_valid`=1 during cycle N+2; new `pc` visible from cycle N+3.
- Run mode: one instruction every 2 cycles; `instr_valid` pattern 0,1,0,1...
- `pc` changes only on the edge that leaves ISSUE; ROM address is stable through FETCH.
- `reset` asserted in any state, any cycle: all outputs take reset values on the next edge; `instr_valid` never pulses in that cycle.

## Configuration
- `FETCH_PC_WRAP_EN` defined: `pc`=7 with no branch wraps to 0 and execution continues.
- Not defined: non-branching ISSUE at `pc`=7 issues that instruction, then goes to HALTED with `pc` held at 7. A taken branch at `pc`=7 proceeds normally.

## Test plan
- Reset: hold `reset` 2 cycles mid-run -> `pc`=0, `instr_out`=0, `instr_valid`=0, `halted`=0 on the following edge.
- Single step: `run`=0, ROM[0]=12'h000, ROM[1]=12'h011; one `step` pulse -> exactly one `instr_valid` pulse 2 cycles after the edge with `instr_out`=12'h000, then `pc`=1. Held `step` produces no further pulses.
- Free run: `run`=1, no branches, no halt opcodes -> `instr_valid` every 2nd cycle, `pc` sequence 0,1,2,...,7.
- Branch: in ISSUE at `pc`=2, `branch_taken`=1, `branch_target`=5 -> next `pc`=5, next `instr_out`=ROM[5].
- Halt: ROM[3]=12'hE00 -> `instr_valid` pulses for it, then `halted`=1, `pc`=3 held for 20 cycles despite `step`/`run`.
- End of ROM: free-run past `pc`=7 -> without `FETCH_PC_WRAP_EN`, `halted`=1 with `pc`=7; with it, `pc`=0 and run continues.
